// File: rtl/dsm_param_top.sv
// dsm_param_top: parametrised delta-sigma modulator.
//   An ORDER-stage chain of saturating integrators feeds a 3-level quantizer
//   that drives the PWM power stage. A run of saturating ticks triggers a
//   recovery period that clears the loop state.
//
// Ports:
//   clock      - system clock
//   reset      - asynchronous active-low reset
//   en         - sample strobe; state advances only on edges with en=1
//   vin        - signed input sample (W bits)
//   pwm        - 00 = 0, 01 = +1, 11 = -1 (10 is never driven)
//   pwm_valid  - one-cycle pulse accompanying each pwm update
//   recovering - high while the loop is held in recovery
//   ovl_events - number of recovery entries, saturating at 255
//
// Build option: define DSM_DITHER_EN to add LFSR dither (-8..+7) to the
// quantizer input. Without it, no LFSR is built and the dither term is zero.
module dsm_param_top #(
  parameter int          W              = 16,
  parameter int          ORDER          = 2,
  parameter int          COEF_SHIFT     = 1,
  parameter logic [W-1:0] FS_HALF       = 16'h2000,
  parameter logic [W-1:0] THRESH        = 16'h1000,
  parameter int          OVL_LIMIT      = 4,
  parameter int          RECOVER_CYCLES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] vin,
  output logic [1:0]          pwm,
  output logic                pwm_valid,
  output logic                recovering,
  output logic [7:0]          ovl_events
);

  // Two guard bits leave room for three W-bit terms without overflow.
  localparam int WX = W + 2;
  localparam logic signed [WX-1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [WX-1:0] MIN_V = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [WX-1:0] FS_X  = {2'b00, FS_HALF};
  localparam logic signed [WX-1:0] THR_X = {2'b00, THRESH};

  typedef enum logic {RUN, RECOVER} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   integ_q   [ORDER];
  logic signed [W-1:0]   integ_d   [ORDER];
  logic signed [W-1:0]   integ_run [ORDER];
  logic signed [WX-1:0]  acc       [ORDER];
  logic                  any_sat;
  logic signed [WX-1:0]  fb;
  logic signed [WX-1:0]  dither;
  logic signed [WX-1:0]  q_x;
  logic signed [W-1:0]   q;
  logic [1:0]            pwm_run, pwm_d;
  logic                  valid_d;
  logic [7:0]            ovl_cnt_q, ovl_cnt_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic [7:0]            events_d;

  function automatic logic signed [WX-1:0] sx(input logic signed [W-1:0] x);
    return {{2{x[W-1]}}, x};
  endfunction

  function automatic logic out_of_range(input logic signed [WX-1:0] x);
    return (x > MAX_V) || (x < MIN_V);
  endfunction

  function automatic logic signed [W-1:0] clamp(input logic signed [WX-1:0] x);
    if (x > MAX_V) return MAX_V[W-1:0];
    if (x < MIN_V) return MIN_V[W-1:0];
    return x[W-1:0];
  endfunction

  // Feedback always follows the currently registered pwm code.
  always_comb begin
    case (pwm)
      2'b01:   fb = FS_X;
      2'b11:   fb = -FS_X;
      default: fb = '0;
    endcase
  end

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; steps on every en tick in any state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  lfsr_q <= 16'hACE1;
    else if (en) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign dither = WX'(lfsr_q[3:0]) - WX'(8);
`else
  assign dither = '0;
`endif

  // Candidate integrator update; any clamp marks the tick as saturating.
  always_comb begin
    any_sat = 1'b0;
    acc[0]  = sx(integ_q[0]) + sx(vin) - fb;
    for (int k = 1; k < ORDER; k++)
      acc[k] = sx(integ_q[k]) + sx(integ_q[k-1] >>> COEF_SHIFT) - fb;
    for (int k = 0; k < ORDER; k++) begin
      integ_run[k] = clamp(acc[k]);
      if (out_of_range(acc[k])) any_sat = 1'b1;
    end
  end

  // Quantizer works on the pre-update last integrator plus vin and dither.
  always_comb begin
    q_x = sx(integ_q[ORDER-1]) + sx(vin) + dither;
    q   = clamp(q_x);
    if (sx(q) < -THR_X)      pwm_run = 2'b11;
    else if (sx(q) >= THR_X) pwm_run = 2'b01;
    else                     pwm_run = 2'b00;
  end

  // Next-state logic: everything holds unless en is high.
  always_comb begin
    state_d   = state_q;
    integ_d   = integ_q;
    pwm_d     = pwm;
    valid_d   = 1'b0;
    ovl_cnt_d = ovl_cnt_q;
    rcnt_d    = rcnt_q;
    events_d  = ovl_events;
    if (en) begin
      valid_d = 1'b1;
      case (state_q)
        RUN: begin
          integ_d = integ_run;
          pwm_d   = pwm_run;
          if (!any_sat) begin
            ovl_cnt_d = '0;
          end else if (ovl_cnt_q == 8'(OVL_LIMIT - 1)) begin
            // Overload confirmed: drop the loop state and sit out the recovery.
            state_d   = RECOVER;
            ovl_cnt_d = '0;
            rcnt_d    = 8'(RECOVER_CYCLES - 1);
            for (int k = 0; k < ORDER; k++) integ_d[k] = '0;
            if (ovl_events != 8'hFF) events_d = ovl_events + 8'd1;
          end else begin
            ovl_cnt_d = ovl_cnt_q + 8'd1;
          end
        end
        RECOVER: begin
          pwm_d = 2'b00;
          if (rcnt_q == 8'd0) state_d = RUN;
          else                rcnt_d  = rcnt_q - 8'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pwm        <= 2'b00;
      pwm_valid  <= 1'b0;
      ovl_cnt_q  <= '0;
      rcnt_q     <= '0;
      ovl_events <= '0;
      for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      pwm        <= pwm_d;
      pwm_valid  <= valid_d;
      ovl_cnt_q  <= ovl_cnt_d;
      rcnt_q     <= rcnt_d;
      ovl_events <= events_d;
      integ_q    <= integ_d;
    end
  end

  assign recovering = (state_q == RECOVER);

endmodule

// File: tb/tb_dsm_param_top.sv
// tb_dsm_param_top: randomized self-checking bench for dsm_param_top.
// A behavioural model (plain integer arithmetic) predicts pwm, pwm_valid,
// recovering, ovl_events and the first/last integrator after every clock.
// With DSM_DITHER_EN defined the model also tracks the dither LFSR.
module tb_dsm_param_top;
  localparam int W              = 16;
  localparam int ORDER          = 2;
  localparam int COEF_SHIFT     = 1;
  localparam int FS             = 'h2000;
  localparam int TH             = 'h1000;
  localparam int OVL_LIMIT      = 4;
  localparam int RECOVER_CYCLES = 8;
  localparam int MAXV           = (1 <<< (W-1)) - 1;
  localparam int MINV           = -(1 <<< (W-1));

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                en    = 1'b0;
  logic signed [W-1:0] vin   = '0;
  logic [1:0]          pwm;
  logic                pwm_valid;
  logic                recovering;
  logic [7:0]          ovl_events;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Model state
  int          mi [ORDER];
  int          m_pwm;
  bit          m_valid;
  bit          m_rec;
  int          m_rcnt;
  int          m_ovl;
  int          m_events;
  logic [15:0] m_lfsr;

  dsm_param_top #(
    .W(W), .ORDER(ORDER), .COEF_SHIFT(COEF_SHIFT),
    .FS_HALF(16'h2000), .THRESH(16'h1000),
    .OVL_LIMIT(OVL_LIMIT), .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .vin(vin),
    .pwm(pwm), .pwm_valid(pwm_valid), .recovering(recovering),
    .ovl_events(ovl_events)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s/%s observed=%0d expected=%0d at %0t", phase, tag, observed, expected, $time);
    end
  endtask

  function automatic int clampv(input int x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic int enc(input int p);
    if (p > 0) return 1;
    if (p < 0) return 3;
    return 0;
  endfunction

  function automatic int dither_now();
`ifdef DSM_DITHER_EN
    return int'(m_lfsr[3:0]) - 8;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ORDER; k++) mi[k] = 0;
    m_pwm = 0; m_valid = 0; m_rec = 0; m_rcnt = 0; m_ovl = 0; m_events = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input bit e, input int v);
    int fb;
    int q;
    int raw;
    bit hit;
    int nxt [ORDER];
    if (!e) begin
      m_valid = 0;
      return;
    end
    m_valid = 1;
    fb = m_pwm * FS;
    if (!m_rec) begin
      hit = 0;
      raw = mi[0] + v - fb;
      nxt[0] = clampv(raw);
      if (nxt[0] != raw) hit = 1;
      for (int k = 1; k < ORDER; k++) begin
        raw = mi[k] + (mi[k-1] >>> COEF_SHIFT) - fb;
        nxt[k] = clampv(raw);
        if (nxt[k] != raw) hit = 1;
      end
      q = clampv(mi[ORDER-1] + v + dither_now());
      m_pwm = (q < -TH) ? -1 : (q >= TH) ? 1 : 0;
      for (int k = 0; k < ORDER; k++) mi[k] = nxt[k];
      if (hit) begin
        m_ovl++;
        if (m_ovl == OVL_LIMIT) begin
          m_ovl = 0;
          m_rec = 1;
          m_rcnt = RECOVER_CYCLES - 1;
          for (int k = 0; k < ORDER; k++) mi[k] = 0;
          if (m_events < 255) m_events++;
        end
      end else begin
        m_ovl = 0;
      end
    end else begin
      m_pwm = 0;
      if (m_rcnt == 0) m_rec = 0;
      else m_rcnt--;
    end
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic applyStimulus(input bit e, input int v);
    en  = e;
    vin = W'(v);
    @(posedge clock);
    model_step(e, v);
    #1;
    checkOutput("pwm", int'(pwm), enc(m_pwm));
    checkOutput("pwm_valid", int'(pwm_valid), int'(m_valid));
    checkOutput("recovering", int'(recovering), int'(m_rec));
    checkOutput("ovl_events", int'(ovl_events), m_events);
    checkOutput("i0", int'(dut.integ_q[0]), mi[0]);
    checkOutput("ilast", int'(dut.integ_q[ORDER-1]), mi[ORDER-1]);
`ifdef DSM_DITHER_EN
    checkOutput("lfsr", int'(dut.lfsr_q), int'(m_lfsr));
`endif
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic doReset();
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_pwm", int'(pwm), 0);
    checkOutput("rst_valid", int'(pwm_valid), 0);
    checkOutput("rst_recovering", int'(recovering), 0);
    checkOutput("rst_events", int'(ovl_events), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_i0", int'(dut.integ_q[0]), 0);
    checkOutput("rst_ilast", int'(dut.integ_q[ORDER-1]), 0);
  endtask

  initial begin
    int v;
    int mode;
    model_reset();
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    phase = "reset";
    doReset();

    phase = "step";
    applyStimulus(1'b1, 'h1800);
    checkOutput("step_i0_1", int'(dut.integ_q[0]), 'h1800);
    checkOutput("step_pwm_1", int'(pwm), 1);
    applyStimulus(1'b1, 'h1800);
    checkOutput("step_i0_2", int'(dut.integ_q[0]), 'h1000);

    phase = "zero";
    doReset();
    for (int n = 0; n < 64; n++) begin
      applyStimulus(1'b1, 0);
      checkOutput("zero_pwm", int'(pwm), 0);
    end

    phase = "gating";
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, int'($urandom_range(0, 16383)) - 8192);
      applyStimulus(1'b0, int'($urandom_range(0, 65535)) - 32768);
      applyStimulus(1'b0, int'($urandom_range(0, 65535)) - 32768);
      applyStimulus(1'b1, int'($urandom_range(0, 16383)) - 8192);
    end

    phase = "overload";
    doReset();
    for (int n = 0; n < 60; n++) applyStimulus(1'b1, 'h7FFF);
    checkOutput("ovl_events_60", int'(ovl_events), m_events);

    phase = "reset_in_recover";
    doReset();
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, 'h7FFF);
    checkOutput("in_recover", int'(recovering), 1);
    doReset();
    applyStimulus(1'b1, 0);

    phase = "random";
    mode = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) mode = int'($urandom_range(0, 3));
      case (mode)
        0:       v = int'($urandom_range(0, 4095)) - 2048;
        1:       v = int'($urandom_range(0, 65535)) - 32768;
        2:       v = 32767 - int'($urandom_range(0, 255));
        default: v = -32768 + int'($urandom_range(0, 255));
      endcase
      applyStimulus($urandom_range(0, 3) != 0, v);
    end

    phase = "events_saturate";
    doReset();
    for (int n = 0; n < 3400; n++) applyStimulus(1'b1, 'h7FFF);
    checkOutput("events_255", int'(ovl_events), 255);

`ifdef DSM_DITHER_EN
    phase = "dither";
    doReset();
    for (int n = 0; n < 32; n++) begin
      applyStimulus(1'b1, 0);
      checkOutput("dither_pwm", int'(pwm), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
